// File: rtl/sdram_sched_pkg.sv
// Shared constants, FSM encoding and address helper for the SDRAM frame scheduler.
// Burst addresses select a ping-pong buffer on one bit and a row above the word offset.
package sdram_sched_pkg;

  localparam int ADDR_W      = 24;
  localparam int BUF_BIT     = 22;
  localparam int BURST_WORDS = 512;
  localparam int ROW_LSB     = $clog2(BURST_WORDS);
  localparam int ROW_W       = 13;
  localparam int CNT_W       = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } sched_state_t;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic buf_sel,
                                                   input logic [ROW_W-1:0] row);
    logic [ADDR_W-1:0] addr;
    addr = '0;
    addr[BUF_BIT] = buf_sel;
    addr[ROW_LSB +: ROW_W] = row;
    return addr;
  endfunction

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Bundle of FIFO levels, burst handshakes and frame status between the scheduler and its neighbours.
interface sdram_frame_arbiter_if;
  import sdram_sched_pkg::*;

  logic              frame_start;
  logic [CNT_W-1:0]  wr_fifo_used;
  logic [CNT_W-1:0]  rd_fifo_used;
  logic              wr_sdram_req;
  logic              wr_sdram_ack;
  logic [ADDR_W-1:0] wr_sdram_add;
  logic              rd_sdram_req;
  logic              rd_sdram_ack;
  logic [ADDR_W-1:0] rd_sdram_add;
  logic              frame_ready;
  logic              wr_stall;

  modport master (
    input  frame_start, wr_fifo_used, rd_fifo_used, wr_sdram_ack, rd_sdram_ack,
    output wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add, frame_ready, wr_stall
  );

  modport slave (
    output frame_start, wr_fifo_used, rd_fifo_used, wr_sdram_ack, rd_sdram_ack,
    input  wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add, frame_ready, wr_stall
  );

endinterface

// File: rtl/sdram_buf_tracker.sv
// Ownership of the two frame buffers: which one the camera fills, which one VGA reads,
// which are full, and whether a frame swap is waiting for the sequencer to go idle.
module sdram_buf_tracker (
  input  logic       clk_100M,
  input  logic       rst_133,
  input  logic       wr_done,
  input  logic       swap_now,
  input  logic       frame_start,
  output logic       wr_buf,
  output logic       rd_buf,
  output logic       swap_pend,
  output logic [1:0] full
);

  // A swap only moves the reader when the other buffer holds a finished frame;
  // otherwise the reader repeats its current frame.
  always_ff @(posedge clk_100M or negedge rst_133) begin
    if (!rst_133) begin
      wr_buf    <= 1'b0;
      rd_buf    <= 1'b1;
      full      <= 2'b00;
      swap_pend <= 1'b0;
    end else begin
      swap_pend <= ~swap_now & (swap_pend | frame_start);
      if (wr_done) begin
        full[wr_buf] <= 1'b1;
        wr_buf       <= ~wr_buf;
      end else if (swap_now && full[~rd_buf]) begin
        full[rd_buf] <= 1'b0;
        rd_buf       <= ~rd_buf;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Single arbitrated sequencer for SDRAM write (camera) and read (VGA) bursts over
// two ping-pong frame buffers.
module sdram_frame_arbiter
  import sdram_sched_pkg::*;
#(
  parameter int ROWS_PER_FRAME = 128,
  parameter int WR_THRESH      = 512,
  parameter int RD_THRESH      = 512
) (
  input logic                   clk_100M,
  input logic                   rst_133,
  sdram_frame_arbiter_if.master sched
);

  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(ROWS_PER_FRAME);
  localparam logic [CNT_W-1:0] WR_TH   = CNT_W'(WR_THRESH);
  localparam logic [CNT_W-1:0] RD_TH   = CNT_W'(RD_THRESH);

  sched_state_t     state;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic [ROW_W-1:0] wr_row_nxt;
  logic             last_rd;
  logic             wr_buf;
  logic             rd_buf;
  logic             swap_pend;
  logic [1:0]       full;
  logic             rd_elig;
  logic             wr_elig;
  logic             swap_now;
  logic             wr_done;
  logic             grant_rd;
  logic             grant_wr;

  sdram_buf_tracker u_buf_tracker (
    .clk_100M    (clk_100M),
    .rst_133     (rst_133),
    .wr_done     (wr_done),
    .swap_now    (swap_now),
    .frame_start (sched.frame_start),
    .wr_buf      (wr_buf),
    .rd_buf      (rd_buf),
    .swap_pend   (swap_pend),
    .full        (full)
  );

  // A frame swap claims the idle cycle outright; on a tie the side not served last wins.
  always_comb begin
    swap_now   = (state == ST_IDLE) & (swap_pend | sched.frame_start);
    rd_elig    = full[rd_buf] & (sched.rd_fifo_used <= RD_TH) & (rd_row < ROW_END) & ~swap_pend;
    wr_elig    = (wr_buf != rd_buf) & ~full[wr_buf] & (sched.wr_fifo_used >= WR_TH);
    grant_rd   = (state == ST_IDLE) & ~swap_now & rd_elig & (~wr_elig | ~last_rd);
    grant_wr   = (state == ST_IDLE) & ~swap_now & wr_elig & ~grant_rd;
    wr_row_nxt = wr_row + 1'b1;
    wr_done    = (state == ST_WR_WAIT) & sched.wr_sdram_ack & (wr_row_nxt == ROW_END);
  end

  always_ff @(posedge clk_100M or negedge rst_133) begin
    if (!rst_133) begin
      state              <= ST_IDLE;
      wr_row             <= '0;
      rd_row             <= '0;
      last_rd            <= 1'b0;
      sched.wr_sdram_req <= 1'b0;
      sched.rd_sdram_req <= 1'b0;
      sched.wr_sdram_add <= burst_addr(1'b0, '0);
      sched.rd_sdram_add <= burst_addr(1'b1, '0);
      sched.frame_ready  <= 1'b0;
      sched.wr_stall     <= 1'b0;
    end else begin
      sched.frame_ready <= full[rd_buf];
      sched.wr_stall    <= ((wr_buf == rd_buf) | full[wr_buf]) & (sched.wr_fifo_used >= WR_TH);
      case (state)
        ST_IDLE: begin
          if (swap_now) begin
            rd_row <= '0;
          end else if (grant_rd) begin
            state              <= ST_RD_WAIT;
            sched.rd_sdram_req <= 1'b1;
            sched.rd_sdram_add <= burst_addr(rd_buf, rd_row);
            last_rd            <= 1'b1;
          end else if (grant_wr) begin
            state              <= ST_WR_WAIT;
            sched.wr_sdram_req <= 1'b1;
            sched.wr_sdram_add <= burst_addr(wr_buf, wr_row);
            last_rd            <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (sched.wr_sdram_ack) begin
            state              <= ST_IDLE;
            sched.wr_sdram_req <= 1'b0;
            wr_row             <= wr_done ? '0 : wr_row_nxt;
          end
        end
        ST_RD_WAIT: begin
          if (sched.rd_sdram_ack) begin
            state              <= ST_IDLE;
            sched.rd_sdram_req <= 1'b0;
            rd_row             <= rd_row + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
